// File: rtl/kbd_pwm_bank.sv
// N-channel PWM bank steered by PS/2 scancodes: digit keys pick a channel, arrows adjust its
// shadow duty, space toggles its enable; shadows load into active duties at each period boundary.
module kbd_pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8,
  parameter int PRESC    = 4,
  parameter int STEP     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          scancode,
  input  logic                flag,
  output logic [CHANNELS-1:0] pwm,
  output logic [3:0]          sel,
  output logic [CNT_W-1:0]    sel_duty,
  output logic                cmd_valid
);

  localparam int                PW         = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESC - 1);
  localparam logic [CNT_W-1:0]  DUTY_MAX   = '1;
  localparam int                STEP_C     = (STEP > (2 ** CNT_W)) ? (2 ** CNT_W) : STEP;
  localparam logic [CNT_W:0]    STEP_X     = (CNT_W + 1)'(STEP_C);
  localparam logic [3:0]        CH_LIM     = 4'(CHANNELS);

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EBRK} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              sel_q, sel_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CHANNELS-1:0]     en_q, en_d;
  logic [CHANNELS-1:0]     pwm_q, pwm_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [CNT_W-1:0]        shadow_q [CHANNELS];
  logic [CNT_W-1:0]        shadow_d [CHANNELS];
  logic [CNT_W-1:0]        active_q [CHANNELS];
  logic [CNT_W-1:0]        active_d [CHANNELS];

  logic                    tick;
  logic [3:0]              digit;
  logic [CNT_W-1:0]        cur_duty;
  logic [CNT_W-1:0]        duty_new;
  logic                    duty_wr;
  logic [CNT_W:0]          sum;

  function automatic logic [3:0] key_digit(input logic [7:0] b);
    case (b)
      8'h16:   key_digit = 4'd1;
      8'h1E:   key_digit = 4'd2;
      8'h26:   key_digit = 4'd3;
      8'h25:   key_digit = 4'd4;
      8'h2E:   key_digit = 4'd5;
      8'h36:   key_digit = 4'd6;
      8'h3D:   key_digit = 4'd7;
      8'h3E:   key_digit = 4'd8;
      8'h46:   key_digit = 4'd9;
      default: key_digit = 4'd0;
    endcase
  endfunction

  always_comb begin
    cur_duty = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel_q == 4'(i)) cur_duty = shadow_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    en_d        = en_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    cmd_valid_d = 1'b0;
    duty_new    = cur_duty;
    duty_wr     = 1'b0;
    sum         = {1'b0, cur_duty} + STEP_X;
    digit       = key_digit(scancode);
    tick        = (presc_q == PRESC_LAST);
    presc_d     = tick ? '0 : presc_q + 1'b1;
    cnt_d       = tick ? cnt_q + 1'b1 : cnt_q;

    if (flag) begin
      case (state_q)
        ST_IDLE: begin
          if (scancode == 8'hE0) begin
            state_d = ST_EXT;
          end else if (scancode == 8'hF0) begin
            state_d = ST_BRK;
          end else if (digit != 4'd0 && digit <= CH_LIM) begin
            sel_d       = digit - 4'd1;
            cmd_valid_d = 1'b1;
          end else if (scancode == 8'h29) begin
            for (int i = 0; i < CHANNELS; i++) begin
              if (sel_q == 4'(i)) en_d[i] = ~en_q[i];
            end
            cmd_valid_d = 1'b1;
          end
        end
        ST_EXT: begin
          if (scancode == 8'hF0) begin
            state_d = ST_EBRK;
          end else begin
            state_d     = ST_IDLE;
            cmd_valid_d = 1'b1;
            duty_wr     = 1'b1;
            case (scancode)
              8'h75:   duty_new = (sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum[CNT_W-1:0];
              8'h72:   duty_new = ({1'b0, cur_duty} < STEP_X) ? '0 : cur_duty - STEP_X[CNT_W-1:0];
              8'h74:   duty_new = DUTY_MAX;
              8'h6B:   duty_new = '0;
              default: begin
                cmd_valid_d = 1'b0;
                duty_wr     = 1'b0;
              end
            endcase
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (duty_wr) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel_q == 4'(i)) shadow_d[i] = duty_new;
      end
    end

    // Boundary loads the post-command shadow so a same-cycle command lands in this period.
    if (tick && cnt_q == DUTY_MAX) active_d = shadow_d;

    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en_d[i] && (cnt_q < active_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      presc_q     <= '0;
      cnt_q       <= '0;
      en_q        <= '1;
      pwm_q       <= '0;
      cmd_valid_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      pwm_q       <= pwm_d;
      cmd_valid_q <= cmd_valid_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  assign pwm       = pwm_q;
  assign sel       = sel_q;
  assign sel_duty  = cur_duty;
  assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_kbd_pwm_bank.sv
// Bench for kbd_pwm_bank: directed vector table, timed corner sequences and random scancode
// streams, all checked cycle by cycle against a time-indexed reference model.
module tb_kbd_pwm_bank;

  localparam int CH     = 4;
  localparam int CW     = 8;
  localparam int PR     = 4;
  localparam int ST     = 16;
  localparam int PERIOD = PR * (2 ** CW);
  localparam int DMAX   = (2 ** CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    scancode = 8'h00;
  logic          flag = 1'b0;
  logic [CH-1:0] pwm;
  logic [3:0]    sel;
  logic [CW-1:0] sel_duty;
  logic          cmd_valid;

  kbd_pwm_bank #(.CHANNELS(CH), .CNT_W(CW), .PRESC(PR), .STEP(ST)) dut (
    .clk(clk), .reset(reset), .scancode(scancode), .flag(flag),
    .pwm(pwm), .sel(sel), .sel_duty(sel_duty), .cmd_valid(cmd_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: time is the number of clock edges since reset.
  int k;
  int m_shadow [CH];
  int m_active [CH];
  bit m_en [CH];
  bit m_pwm [CH];
  int m_sel;
  bit m_cv;
  bit m_pend_ext;
  bit m_pend_rel;
  byte unsigned digit_code [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic f, input logic [7:0] sc);
    int cnt_old;
    int act_old [CH];
    if (r) begin
      k = 0; m_sel = 0; m_cv = 0; m_pend_ext = 0; m_pend_rel = 0;
      for (int i = 0; i < CH; i++) begin
        m_shadow[i] = 0; m_active[i] = 0; m_en[i] = 1; m_pwm[i] = 0;
      end
      return;
    end
    cnt_old = (k / PR) % (2 ** CW);
    act_old = m_active;
    m_cv = 0;
    if (f) begin
      if (m_pend_rel) begin
        m_pend_rel = 0;
        m_pend_ext = 0;
      end else if (m_pend_ext) begin
        if (sc == 8'hF0) m_pend_rel = 1;
        else begin
          m_pend_ext = 0;
          m_cv = 1;
          case (sc)
            8'h75:   m_shadow[m_sel] = (m_shadow[m_sel] + ST > DMAX) ? DMAX : m_shadow[m_sel] + ST;
            8'h72:   m_shadow[m_sel] = (m_shadow[m_sel] - ST < 0) ? 0 : m_shadow[m_sel] - ST;
            8'h74:   m_shadow[m_sel] = DMAX;
            8'h6B:   m_shadow[m_sel] = 0;
            default: m_cv = 0;
          endcase
        end
      end else if (sc == 8'hE0) m_pend_ext = 1;
      else if (sc == 8'hF0) m_pend_rel = 1;
      else if (sc == 8'h29) begin
        m_en[m_sel] = !m_en[m_sel];
        m_cv = 1;
      end else begin
        for (int d = 0; d < 9; d++) begin
          if (sc == digit_code[d] && d < CH) begin
            m_sel = d;
            m_cv = 1;
          end
        end
      end
    end
    if ((k + 1) % PERIOD == 0) m_active = m_shadow;
    for (int i = 0; i < CH; i++) m_pwm[i] = m_en[i] && (cnt_old < act_old[i]);
    k++;
  endtask

  task automatic model_compare();
    logic [CH-1:0] exp_pwm;
    for (int i = 0; i < CH; i++) exp_pwm[i] = m_pwm[i];
    check("model_pwm", int'(pwm), int'(exp_pwm));
    check("model_sel", int'(sel), m_sel);
    check("model_sel_duty", int'(sel_duty), m_shadow[m_sel]);
    check("model_cmd_valid", int'(cmd_valid), int'(m_cv));
  endtask

  task automatic step(input logic r, input logic f, input logic [7:0] sc);
    @(negedge clk);
    reset = r; flag = f; scancode = sc;
    @(posedge clk);
    model_edge(r, f, sc);
    #1;
    model_compare();
  endtask

  task automatic idle_until(input int phase);
    for (int n = 0; n < PERIOD && (k % PERIOD) != phase; n++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic count_high(input int ch, output int hi);
    hi = 0;
    for (int n = 0; n < PERIOD; n++) begin
      step(1'b0, 1'b0, 8'h00);
      if (pwm[ch]) hi++;
    end
  endtask

  typedef struct {
    logic [7:0] sc;
    int         sel;
    int         duty;
    logic       cv;
  } vec_t;

  vec_t tbl [$];

  initial begin
    bit cv_seen;
    bit pwm_seen;
    int hi;
    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h74, 8'h6B, 8'h29,
                              8'h16, 8'h1E, 8'h26, 8'h25, 8'h46, 8'h3D, 8'h00};

    tbl.push_back('{8'hE0, 0, 0, 1'b0});
    tbl.push_back('{8'h75, 0, 16, 1'b1});
    tbl.push_back('{8'hE0, 0, 16, 1'b0});
    tbl.push_back('{8'h75, 0, 32, 1'b1});
    tbl.push_back('{8'hE0, 0, 32, 1'b0});
    tbl.push_back('{8'h75, 0, 48, 1'b1});
    tbl.push_back('{8'hE0, 0, 48, 1'b0});
    tbl.push_back('{8'hF0, 0, 48, 1'b0});
    tbl.push_back('{8'h75, 0, 48, 1'b0});
    tbl.push_back('{8'h00, 0, 48, 1'b0});
    tbl.push_back('{8'h25, 3, 0, 1'b1});
    tbl.push_back('{8'h46, 3, 0, 1'b0});
    tbl.push_back('{8'hE0, 3, 0, 1'b0});
    tbl.push_back('{8'h74, 3, 255, 1'b1});
    tbl.push_back('{8'hE0, 3, 255, 1'b0});
    tbl.push_back('{8'h75, 3, 255, 1'b1});
    tbl.push_back('{8'hE0, 3, 255, 1'b0});
    tbl.push_back('{8'h6B, 3, 0, 1'b1});
    tbl.push_back('{8'hE0, 3, 0, 1'b0});
    tbl.push_back('{8'h75, 3, 16, 1'b1});
    tbl.push_back('{8'hE0, 3, 16, 1'b0});
    tbl.push_back('{8'h72, 3, 0, 1'b1});
    tbl.push_back('{8'hE0, 3, 0, 1'b0});
    tbl.push_back('{8'h72, 3, 0, 1'b1});
    tbl.push_back('{8'h16, 0, 48, 1'b1});
    tbl.push_back('{8'h29, 0, 48, 1'b1});
    tbl.push_back('{8'h29, 0, 48, 1'b1});

    // Reset state, then three quiet periods.
    step(1'b1, 1'b0, 8'h00);
    check("reset_pwm", int'(pwm), 0);
    check("reset_sel", int'(sel), 0);
    check("reset_sel_duty", int'(sel_duty), 0);
    check("reset_cmd_valid", int'(cmd_valid), 0);
    cv_seen = 0; pwm_seen = 0;
    for (int n = 0; n < 3 * PERIOD; n++) begin
      step(1'b0, 1'b0, 8'h00);
      if (cmd_valid) cv_seen = 1;
      if (pwm != '0) pwm_seen = 1;
    end
    check("idle_cmd_valid_seen", int'(cv_seen), 0);
    check("idle_pwm_seen", int'(pwm_seen), 0);

    // Back-to-back command bytes on consecutive cycles.
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, 1'b1, tbl[i].sc);
      check($sformatf("vec%0d_sel", i), int'(sel), tbl[i].sel);
      check($sformatf("vec%0d_duty", i), int'(sel_duty), tbl[i].duty);
      check($sformatf("vec%0d_cv", i), int'(cmd_valid), int'(tbl[i].cv));
    end

    // Channel 0 at duty 48 from the next boundary.
    idle_until(0);
    count_high(0, hi);
    check("ch0_duty48_high_cycles", hi, 48 * PR);

    // Command whose flag edge is exactly the boundary edge.
    step(1'b0, 1'b1, 8'h26);
    step(1'b0, 1'b1, 8'hE0);
    idle_until(PERIOD - 1);
    step(1'b0, 1'b1, 8'h74);
    check("boundary_cmd_k_phase", k % PERIOD, 0);
    count_high(2, hi);
    check("boundary_cmd_high_cycles", hi, DMAX * PR);

    // Space toggles channel 1 off mid-period and back on with its old duty.
    step(1'b0, 1'b1, 8'h1E);
    step(1'b0, 1'b1, 8'hE0);
    step(1'b0, 1'b1, 8'h74);
    idle_until(0);
    for (int n = 0; n < 100; n++) step(1'b0, 1'b0, 8'h00);
    check("ch1_on_before_space", int'(pwm[1]), 1);
    step(1'b0, 1'b1, 8'h29);
    check("space_off_next_cycle", int'(pwm[1]), 0);
    for (int n = 0; n < 50; n++) step(1'b0, 1'b0, 8'h00);
    check("space_off_holds", int'(pwm[1]), 0);
    check("space_keeps_duty", int'(sel_duty), DMAX);
    step(1'b0, 1'b1, 8'h29);
    step(1'b0, 1'b0, 8'h00);
    check("space_on_resumes", int'(pwm[1]), 1);

    // Reset between E0 and its code byte, with a flag in the reset cycle.
    step(1'b0, 1'b1, 8'hE0);
    step(1'b1, 1'b1, 8'h26);
    check("rst_flag_dropped_sel", int'(sel), 0);
    step(1'b0, 1'b1, 8'h75);
    check("rst_mid_seq_cv", int'(cmd_valid), 0);
    check("rst_mid_seq_duty", int'(sel_duty), 0);

    // Random scancode streams against the model.
    for (int n = 0; n < 6000; n++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 13)];
      step(($urandom_range(0, 799) == 0), ($urandom_range(0, 2) != 0), b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
